// File: rtl/greenhouse_pkg.sv
// Shared types and constants for the greenhouse status receiver.
// Optional feature macro used elsewhere: STATUS_TIMEOUT_EN.
package greenhouse_pkg;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int HALF_BIT   = 8;

    localparam logic [3:0] STATUS_FAIL   = 4'h0;
    localparam logic [3:0] STATUS_ALL_OK = 4'hF;

endpackage

// File: rtl/module_status_receiver_if.sv
// Serial line and status outputs of the greenhouse status receiver.
// Bundles the pins that cross from the GPIO side to the display path.
interface module_status_receiver_if;

    logic       UART_RX;
    logic [3:0] MODULE1_STATUS;
    logic       STATUS_VALID;
    logic       FRAME_ERR;
    logic       STATUS_STALE;

    modport master (
        output UART_RX,
        input  MODULE1_STATUS,
        input  STATUS_VALID,
        input  FRAME_ERR,
        input  STATUS_STALE
    );

    modport slave (
        input  UART_RX,
        output MODULE1_STATUS,
        output STATUS_VALID,
        output FRAME_ERR,
        output STATUS_STALE
    );

endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchronizer, 16x oversample tick, framing FSM.
// Emits the received byte with one-cycle done / framing-error pulses.
module uart_rx_core
    import greenhouse_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_done,
    output logic       rx_err
);

    localparam logic [2:0] IDLE      = 3'(RX_IDLE);
    localparam logic [2:0] START     = 3'(RX_START);
    localparam logic [2:0] DATA      = 3'(RX_DATA);
    localparam logic [2:0] STOP      = 3'(RX_STOP);
    localparam logic [2:0] WAIT_IDLE = 3'(RX_WAIT_IDLE);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_MAX = CW'(DIV - 1);
    localparam logic [3:0] HALF_MAX = 4'(HALF_BIT - 1);
    localparam logic [3:0] BIT_MAX  = 4'(OVERSAMPLE - 1);

    logic          sync1;
    logic          sync2;
    logic          rx_s;
    logic [CW-1:0] div_cnt;
    logic          tick;
    logic [2:0]    state;
    logic [3:0]    tick_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          start_edge;
    logic          stop_sample;

    assign rx_s        = sync2;
    assign tick        = (div_cnt == DIV_MAX);
    assign start_edge  = (state == IDLE) && !rx_s;
    assign stop_sample = (state == STOP) && tick && (tick_cnt == BIT_MAX);
    assign rx_done     = stop_sample && rx_s;
    assign rx_err      = stop_sample && !rx_s;
    assign rx_byte     = shreg;

    // Bring the asynchronous line into the clock domain; idle level is 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
        end
    end

    // Oversample divider, realigned to the start edge of every frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (start_edge || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Frame state machine: mid-bit sampling of start, data and stop bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tick_cnt == HALF_MAX) begin
                            tick_cnt <= '0;
                            bit_idx  <= '0;
                            state    <= rx_s ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tick_cnt == BIT_MAX) begin
                            tick_cnt <= '0;
                            shreg    <= {rx_s, shreg[7:1]};
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (tick_cnt == BIT_MAX) begin
                            tick_cnt <= '0;
                            state    <= rx_s ? IDLE : WAIT_IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                WAIT_IDLE: begin
                    tick_cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/module_status_receiver.sv
// Greenhouse module status receiver: UART frame -> 4-bit indicator word.
// Define STATUS_TIMEOUT_EN to force fail-safe status after line silence.
module module_status_receiver
    import greenhouse_pkg::*;
#(
    parameter int         CLK_HZ         = 50_000_000,
    parameter int         BAUD           = 9600,
    parameter logic [3:0] MODULE_ID      = 4'h1,
    parameter int         TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    module_status_receiver_if.slave bus
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;

    logic [7:0] rx_byte;
    logic       rx_done;
    logic       rx_err;
    logic       accept;
    logic [3:0] status_q;
    logic       valid_q;
    logic       err_q;
    logic       stale_q;
    logic       expire;

    uart_rx_core #(
        .DIV(DIV)
    ) u_core (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .rx      (bus.UART_RX),
        .rx_byte (rx_byte),
        .rx_done (rx_done),
        .rx_err  (rx_err)
    );

    assign accept = rx_done && (rx_byte[7:4] == MODULE_ID);

`ifdef STATUS_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt;

    assign expire = (to_cnt == TO_MAX);

    // Silence timer: restarts on each accepted frame, saturates when stale.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            to_cnt <= '0;
        end else if (accept) begin
            to_cnt <= '0;
        end else if (!expire) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign expire = 1'b0;
`endif

    // Output registers: accepted frames win over timeout expiry.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            status_q <= STATUS_FAIL;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            stale_q  <= 1'b1;
        end else begin
            valid_q <= accept;
            err_q   <= rx_err;
            if (accept) begin
                status_q <= rx_byte[3:0];
                stale_q  <= 1'b0;
            end else if (expire) begin
                status_q <= STATUS_FAIL;
                stale_q  <= 1'b1;
            end
        end
    end

    assign bus.MODULE1_STATUS = status_q;
    assign bus.STATUS_VALID   = valid_q;
    assign bus.FRAME_ERR      = err_q;
    assign bus.STATUS_STALE   = stale_q;

endmodule
